// File: rtl/irq_controller_if.sv
// Word-addressed register port between software (master) and the interrupt controller (slave).
interface irq_controller_if;
  logic [2:0]  bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_we;
  logic        bus_re;
  logic [31:0] bus_rdata;

  modport master (output bus_addr, bus_wdata, bus_we, bus_re, input bus_rdata);
  modport slave  (input bus_addr, bus_wdata, bus_we, bus_re, output bus_rdata);
endinterface

// File: rtl/irq_controller.sv
// Machine-level interrupt controller: edge-latched external lines, 64-bit mtime/mtimecmp timer,
// fixed-priority arbitration with claim/complete, and a trap handshake FSM driving 'interrupt'.
module irq_controller #(
  parameter int N_EXT = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_EXT-1:0] ext_irq,
  irq_controller_if.slave  bus,
  input  logic             mie_global,
  input  logic             trap_taken,
  input  logic             mret,
  output logic             interrupt,
  output logic [4:0]       irq_id
);
  localparam logic [2:0] A_PENDING  = 3'd0;
  localparam logic [2:0] A_ENABLE   = 3'd1;
  localparam logic [2:0] A_CLAIM    = 3'd2;
  localparam logic [2:0] A_MTIME_LO = 3'd3;
  localparam logic [2:0] A_MTIME_HI = 3'd4;
  localparam logic [2:0] A_CMP_LO   = 3'd5;
  localparam logic [2:0] A_CMP_HI   = 3'd6;

  typedef enum logic [1:0] {IDLE, ASSERT, IN_TRAP} state_t;

  state_t           state;
  logic [N_EXT-1:0] ext_prev;
  logic [N_EXT-1:0] rise;
  logic [N_EXT-1:0] pending;
  logic [N_EXT-1:0] in_service;
  logic [N_EXT-1:0] enable_ext;
  logic [N_EXT-1:0] active;
  logic             enable_tmr;
  logic [63:0]      mtime;
  logic [63:0]      mtimecmp;
  logic             timer_pending;
  logic             timer_active;
  logic [4:0]       winner;
  logic             req;
  logic             wr;
  logic             rd;
  logic             claim_ext;
  logic [31:0]      rd_value;

  // A simultaneous read and write is treated as a write only.
  assign wr = bus.bus_we;
  assign rd = bus.bus_re && !bus.bus_we;

  assign rise          = ext_irq & ~ext_prev;
  assign timer_pending = (mtime >= mtimecmp);
  assign timer_active  = timer_pending && enable_tmr;
  assign active        = pending & enable_ext & ~in_service;
  assign req           = (|active) || timer_active;

  always_comb begin
    winner = 5'd0;
    for (int i = N_EXT - 1; i >= 0; i--) begin
      if (active[i]) winner = 5'(i + 1);
    end
    if (timer_active) winner = 5'd31;
  end

  // The timer has no pending latch, so only external winners are claimed.
  assign claim_ext = rd && (bus.bus_addr == A_CLAIM) && (winner != 5'd0) && (winner != 5'd31);

  for (genvar gi = 0; gi < N_EXT; gi++) begin : g_line
    logic pend_reg;
    logic insvc_reg;
    logic claim_hit;
    logic complete_hit;

    assign claim_hit    = claim_ext && (winner == 5'(gi + 1));
    assign complete_hit = wr && (bus.bus_addr == A_CLAIM) && (bus.bus_wdata == 32'(gi + 1));

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        pend_reg  <= 1'b0;
        insvc_reg <= 1'b0;
      end else begin
        if (rise[gi])       pend_reg <= 1'b1;
        else if (claim_hit) pend_reg <= 1'b0;
        if (claim_hit)         insvc_reg <= 1'b1;
        else if (complete_hit) insvc_reg <= 1'b0;
      end
    end

    assign pending[gi]    = pend_reg;
    assign in_service[gi] = insvc_reg;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ext_prev   <= '0;
      enable_ext <= '0;
      enable_tmr <= 1'b0;
      mtime      <= 64'd0;
      mtimecmp   <= 64'hFFFF_FFFF_FFFF_FFFF;
      irq_id     <= 5'd0;
    end else begin
      ext_prev <= ext_irq;
      irq_id   <= winner;
      if (wr && bus.bus_addr == A_ENABLE) begin
        enable_ext <= bus.bus_wdata[N_EXT-1:0];
        enable_tmr <= bus.bus_wdata[31];
      end
      if (wr && bus.bus_addr == A_MTIME_LO)      mtime[31:0]  <= bus.bus_wdata;
      else if (wr && bus.bus_addr == A_MTIME_HI) mtime[63:32] <= bus.bus_wdata;
      else                                       mtime        <= mtime + 64'd1;
      if (wr && bus.bus_addr == A_CMP_LO) mtimecmp[31:0]  <= bus.bus_wdata;
      if (wr && bus.bus_addr == A_CMP_HI) mtimecmp[63:32] <= bus.bus_wdata;
    end
  end

  always_comb begin
    rd_value = 32'd0;
    case (bus.bus_addr)
      A_PENDING:  rd_value = {timer_pending, {(31 - N_EXT){1'b0}}, pending};
      A_ENABLE:   rd_value = {enable_tmr, {(31 - N_EXT){1'b0}}, enable_ext};
      A_CLAIM:    rd_value = {27'd0, winner};
      A_MTIME_LO: rd_value = mtime[31:0];
      A_MTIME_HI: rd_value = mtime[63:32];
      A_CMP_LO:   rd_value = mtimecmp[31:0];
      A_CMP_HI:   rd_value = mtimecmp[63:32];
      default:    rd_value = 32'd0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)             bus.bus_rdata <= 32'd0;
    else if (bus.bus_we) bus.bus_rdata <= 32'd0;
    else if (bus.bus_re) bus.bus_rdata <= rd_value;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      interrupt <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req && mie_global) begin
            state     <= ASSERT;
            interrupt <= 1'b1;
          end
        end
        ASSERT: begin
          if (trap_taken) begin
            state     <= IN_TRAP;
            interrupt <= 1'b0;
          end else if (!req || !mie_global) begin
            state     <= IDLE;
            interrupt <= 1'b0;
          end
        end
        IN_TRAP: begin
          interrupt <= 1'b0;
          if (mret) state <= IDLE;
        end
        default: begin
          state     <= IDLE;
          interrupt <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_irq_controller.sv
// Directed bench for irq_controller: reset, bus map, single irq, priority, timer, gating, wrap, async reset.
module tb_irq_controller;
  logic       clk;
  logic       rst;
  logic [7:0] ext_irq;
  logic       mie_global;
  logic       trap_taken;
  logic       mret;
  logic       interrupt;
  logic [4:0] irq_id;
  int checks = 0;
  int errors = 0;

  irq_controller_if bus();

  irq_controller #(.N_EXT(8)) dut (
    .clk(clk), .rst(rst), .ext_irq(ext_irq), .bus(bus),
    .mie_global(mie_global), .trap_taken(trap_taken), .mret(mret),
    .interrupt(interrupt), .irq_id(irq_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    bus.bus_addr = a; bus.bus_wdata = d; bus.bus_we = 1'b1;
    tick();
    bus.bus_we = 1'b0;
    $display("bus write addr %0d data %08h", a, d);
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
    bus.bus_addr = a; bus.bus_re = 1'b1;
    tick();
    bus.bus_re = 1'b0;
    d = bus.bus_rdata;
    $display("bus read  addr %0d data %08h", a, d);
  endtask

  task automatic pulse_ext(input logic [7:0] m);
    ext_irq = m;
    tick();
    ext_irq = 8'h00;
  endtask

  task automatic pulse_trap();
    trap_taken = 1'b1; tick(); trap_taken = 1'b0;
  endtask

  task automatic pulse_mret();
    mret = 1'b1; tick(); mret = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    rst = 1'b1;
    repeat (3) tick();
    checks++; if (interrupt !== 1'b0) begin errors++; $display("FAIL reset_int got %b exp 0", interrupt); end
    checks++; if (irq_id !== 5'd0) begin errors++; $display("FAIL reset_id got %0d exp 0", irq_id); end
    checks++; if (bus.bus_rdata !== 32'd0) begin errors++; $display("FAIL reset_rdata got %08h exp 0", bus.bus_rdata); end
    rst = 1'b0;
    bus_read(3'd5, d);
    checks++; if (d !== 32'hFFFF_FFFF) begin errors++; $display("FAIL reset_cmp_lo got %08h exp ffffffff", d); end
    bus_read(3'd6, d);
    checks++; if (d !== 32'hFFFF_FFFF) begin errors++; $display("FAIL reset_cmp_hi got %08h exp ffffffff", d); end
    bus_read(3'd3, d);
    checks++; if (!(d < 32'd16)) begin errors++; $display("FAIL reset_mtime got %08h exp <16", d); end
    bus_read(3'd1, d);
    checks++; if (d !== 32'd0) begin errors++; $display("FAIL reset_enable got %08h exp 0", d); end
  endtask

  task automatic test_bus();
    logic [31:0] d;
    bus_write(3'd1, 32'hFFFF_FFFF);
    bus_read(3'd1, d);
    checks++; if (d !== 32'h8000_00FF) begin errors++; $display("FAIL enable_mask got %08h exp 800000ff", d); end
    bus.bus_addr = 3'd1; bus.bus_wdata = 32'h5; bus.bus_we = 1'b1; bus.bus_re = 1'b1;
    tick();
    bus.bus_we = 1'b0; bus.bus_re = 1'b0;
    $display("bus rd+wr addr 1 data 00000005 rdata %08h", bus.bus_rdata);
    checks++; if (bus.bus_rdata !== 32'd0) begin errors++; $display("FAIL rdwr_rdata got %08h exp 0", bus.bus_rdata); end
    bus_read(3'd1, d);
    checks++; if (d !== 32'h5) begin errors++; $display("FAIL rdwr_write got %08h exp 5", d); end
    bus_write(3'd0, 32'hFF);
    bus_read(3'd0, d);
    checks++; if (d !== 32'd0) begin errors++; $display("FAIL pending_ro got %08h exp 0", d); end
    bus_read(3'd7, d);
    checks++; if (d !== 32'd0) begin errors++; $display("FAIL addr7 got %08h exp 0", d); end
    bus_write(3'd1, 32'd0);
  endtask

  task automatic test_single_irq();
    logic [31:0] d;
    bus_write(3'd1, 32'h4);
    mie_global = 1'b1;
    ext_irq = 8'h04;
    checks++; if (interrupt !== 1'b0) begin errors++; $display("FAIL single_t0 got %b exp 0", interrupt); end
    tick();
    ext_irq = 8'h00;
    checks++; if (interrupt !== 1'b0) begin errors++; $display("FAIL single_t1 got %b exp 0", interrupt); end
    bus_read(3'd0, d);
    checks++; if (d !== 32'h4) begin errors++; $display("FAIL single_pending got %08h exp 4", d); end
    checks++; if (interrupt !== 1'b1) begin errors++; $display("FAIL single_t2 got %b exp 1", interrupt); end
    checks++; if (irq_id !== 5'd3) begin errors++; $display("FAIL single_id got %0d exp 3", irq_id); end
    pulse_trap();
    checks++; if (interrupt !== 1'b0) begin errors++; $display("FAIL single_trap got %b exp 0", interrupt); end
    bus_read(3'd2, d);
    checks++; if (d !== 32'd3) begin errors++; $display("FAIL single_claim got %0d exp 3", d); end
    bus_read(3'd0, d);
    checks++; if (d !== 32'd0) begin errors++; $display("FAIL single_cleared got %08h exp 0", d); end
    pulse_mret();
    bus_write(3'd2, 32'd3);
    tick();
    checks++; if (interrupt !== 1'b0) begin errors++; $display("FAIL single_idle got %b exp 0", interrupt); end
  endtask

  task automatic test_priority();
    logic [31:0] d;
    bus_write(3'd1, 32'hFF);
    pulse_ext(8'h22);
    bus_read(3'd2, d);
    checks++; if (d !== 32'd2) begin errors++; $display("FAIL prio_first got %0d exp 2", d); end
    bus_read(3'd2, d);
    checks++; if (d !== 32'd6) begin errors++; $display("FAIL prio_second got %0d exp 6", d); end
    bus_read(3'd2, d);
    checks++; if (d !== 32'd0) begin errors++; $display("FAIL prio_empty got %0d exp 0", d); end
    pulse_ext(8'h02);
    tick();
    bus_read(3'd0, d);
    checks++; if (d !== 32'h2) begin errors++; $display("FAIL prio_repend got %08h exp 2", d); end
    bus_read(3'd2, d);
    checks++; if (d !== 32'd0) begin errors++; $display("FAIL prio_masked got %0d exp 0", d); end
    checks++; if (interrupt !== 1'b0) begin errors++; $display("FAIL prio_masked_int got %b exp 0", interrupt); end
    bus_write(3'd2, 32'd2);
    bus_read(3'd2, d);
    checks++; if (d !== 32'd2) begin errors++; $display("FAIL prio_complete got %0d exp 2", d); end
    bus_write(3'd2, 32'd2);
    bus_write(3'd2, 32'd6);
    tick();
    checks++; if (interrupt !== 1'b0) begin errors++; $display("FAIL prio_done got %b exp 0", interrupt); end
  endtask

  task automatic test_timer();
    logic [31:0] d;
    int n;
    bus_write(3'd1, 32'h8000_0000);
    bus_write(3'd4, 32'd0);
    bus_write(3'd3, 32'd0);
    bus_write(3'd5, 32'd12);
    bus_write(3'd6, 32'd0);
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (interrupt) begin n = i; break; end
    end
    checks++; if (n !== 11) begin errors++; $display("FAIL timer_latency got %0d exp 11", n); end
    checks++; if (irq_id !== 5'd31) begin errors++; $display("FAIL timer_id got %0d exp 31", irq_id); end
    bus_read(3'd0, d);
    checks++; if (d !== 32'h8000_0000) begin errors++; $display("FAIL timer_pending got %08h exp 80000000", d); end
    bus_write(3'd6, 32'hFFFF_FFFF);
    bus_read(3'd0, d);
    checks++; if (d !== 32'd0) begin errors++; $display("FAIL timer_clear got %08h exp 0", d); end
    checks++; if (interrupt !== 1'b0) begin errors++; $display("FAIL timer_drop got %b exp 0", interrupt); end
    bus_write(3'd5, 32'hFFFF_FFFF);
    bus_write(3'd1, 32'd0);
  endtask

  task automatic test_gating();
    logic [31:0] d;
    logic seen;
    mie_global = 1'b0;
    bus_write(3'd1, 32'h3);
    pulse_ext(8'h01);
    seen = 1'b0;
    repeat (20) begin tick(); if (interrupt) seen = 1'b1; end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL gate_mie0 got %b exp 0", seen); end
    mie_global = 1'b1;
    tick();
    checks++; if (interrupt !== 1'b1) begin errors++; $display("FAIL gate_mie1 got %b exp 1", interrupt); end
    pulse_trap();
    checks++; if (interrupt !== 1'b0) begin errors++; $display("FAIL gate_trap got %b exp 0", interrupt); end
    bus_read(3'd2, d);
    checks++; if (d !== 32'd1) begin errors++; $display("FAIL gate_claim got %0d exp 1", d); end
    pulse_ext(8'h02);
    seen = 1'b0;
    repeat (5) begin tick(); if (interrupt) seen = 1'b1; end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL gate_intrap got %b exp 0", seen); end
    pulse_mret();
    checks++; if (interrupt !== 1'b0) begin errors++; $display("FAIL gate_mret got %b exp 0", interrupt); end
    tick();
    checks++; if (interrupt !== 1'b1) begin errors++; $display("FAIL gate_reassert got %b exp 1", interrupt); end
    pulse_trap();
    bus_read(3'd2, d);
    checks++; if (d !== 32'd2) begin errors++; $display("FAIL gate_claim2 got %0d exp 2", d); end
    bus_write(3'd2, 32'd1);
    bus_write(3'd2, 32'd2);
    pulse_mret();
  endtask

  task automatic test_wrap();
    logic [31:0] d;
    bus_write(3'd1, 32'd0);
    bus_write(3'd4, 32'hFFFF_FFFF);
    bus_write(3'd3, 32'hFFFF_FFFE);
    tick();
    tick();
    bus_read(3'd4, d);
    checks++; if (d !== 32'd0) begin errors++; $display("FAIL wrap_hi got %08h exp 0", d); end
    bus_read(3'd3, d);
    checks++; if (d !== 32'd1) begin errors++; $display("FAIL wrap_lo got %08h exp 1", d); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    bus_write(3'd1, 32'h1);
    mie_global = 1'b1;
    pulse_ext(8'h01);
    tick();
    checks++; if (interrupt !== 1'b1) begin errors++; $display("FAIL rstmid_pre got %b exp 1", interrupt); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (interrupt !== 1'b0) begin errors++; $display("FAIL rstmid_async got %b exp 0", interrupt); end
    tick();
    rst = 1'b0;
    bus_read(3'd1, d);
    checks++; if (d !== 32'd0) begin errors++; $display("FAIL rstmid_enable got %08h exp 0", d); end
    bus_read(3'd0, d);
    checks++; if (d !== 32'd0) begin errors++; $display("FAIL rstmid_pending got %08h exp 0", d); end
    bus_read(3'd5, d);
    checks++; if (d !== 32'hFFFF_FFFF) begin errors++; $display("FAIL rstmid_cmp got %08h exp ffffffff", d); end
    bus_read(3'd3, d);
    checks++; if (!(d < 32'd16)) begin errors++; $display("FAIL rstmid_mtime got %08h exp <16", d); end
  endtask

  initial begin
    rst = 1'b1;
    ext_irq = 8'h00;
    mie_global = 1'b0;
    trap_taken = 1'b0;
    mret = 1'b0;
    bus.bus_addr = 3'd0;
    bus.bus_wdata = 32'd0;
    bus.bus_we = 1'b0;
    bus.bus_re = 1'b0;
    test_reset();
    test_bus();
    test_single_irq();
    test_priority();
    test_timer();
    test_gating();
    test_wrap();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
